// File: rtl/etai_err_monitor_if.sv
// ---------------------------------------------------------------------------
// etai_err_monitor_if
// Operand/result stream bundle for the ETAI error monitor.
//   in_valid  : operand pair valid            (master -> slave)
//   in_ready  : monitor accepts operands      (slave  -> master)
//   data_a/b  : signed operands, WIDTH bits   (master -> slave)
//   out_valid : per-sample result valid       (slave  -> master)
//   appx_sum  : ETAI result, WIDTH+1 signed   (slave  -> master)
//   exact_sum : exact result, WIDTH+1 signed  (slave  -> master)
// ---------------------------------------------------------------------------
interface etai_err_monitor_if #(
    parameter int WIDTH = 32
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] data_a;
    logic signed [WIDTH-1:0] data_b;
    logic                    out_valid;
    logic signed [WIDTH:0]   appx_sum;
    logic signed [WIDTH:0]   exact_sum;

    modport master (
        output in_valid, data_a, data_b,
        input  in_ready, out_valid, appx_sum, exact_sum
    );

    modport slave (
        input  in_valid, data_a, data_b,
        output in_ready, out_valid, appx_sum, exact_sum
    );
endinterface

// File: rtl/etai_err_monitor.sv
// ---------------------------------------------------------------------------
// etai_err_monitor
// Runs an ETAI approximate adder next to an exact adder over a programmed
// window of operand pairs and accumulates error metrics in hardware.
// Ports:
//   Clk, Rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : pulse, clears metrics and opens a window (IDLE/DONE only)
//   num_samples : window length, latched on an accepted start
//   bus         : operand/result stream (slave modport)
//   sum_ae      : saturating sum of |AE|
//   sum_se      : saturating sum of AE^2
//   max_ae      : largest |AE| seen in the window
//   err_cnt     : number of samples with AE != 0 (saturating)
//   busy / done : window in progress / window finished, metrics stable
// ---------------------------------------------------------------------------
module etai_err_monitor #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16,
    parameter int ACC_W = 96,
    parameter int CNT_W = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    etai_err_monitor_if.slave  bus,
    output logic [ACC_W-1:0]   sum_ae,
    output logic [ACC_W-1:0]   sum_se,
    output logic [WIDTH+1:0]   max_ae,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               busy,
    output logic               done
);
    localparam int UP_W  = WIDTH - SPLIT;
    localparam int AE_W  = WIDTH + 2;
    localparam int SQ_W  = 2 * AE_W;
    // One bit wider than both operands so a carry out of ACC_W is visible.
    localparam int EXT_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] target;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [AE_W-1:0]  s2_abs;
    logic             s3_valid;

    logic             transfer;
    logic [CNT_W-1:0] cnt_next;
    logic             metric_en;

    assign transfer  = bus.in_valid && bus.in_ready;
    assign cnt_next  = sample_cnt + CNT_W'(1);
    assign metric_en = s2_valid && ((state == RUN) || (state == DRAIN));

    // ETAI lower part: XOR until the first (from the MSB) position where both
    // operands are 1; that position and everything below it is forced to 1.
    logic [SPLIT-1:0] lower;
    logic             found;
    always_comb begin
        lower = '0;
        found = 1'b0;
        for (int i = SPLIT - 1; i >= 0; i--) begin
            if (found || (s1_a[i] && s1_b[i])) begin
                lower[i] = 1'b1;
                found    = 1'b1;
            end else begin
                lower[i] = s1_a[i] ^ s1_b[i];
            end
        end
    end

    // Upper part adds sign-extended upper slices with no carry from below.
    logic [UP_W:0]    upper;
    logic [WIDTH:0]   appx_c;
    logic [WIDTH:0]   exact_c;
    logic [AE_W-1:0]  ae;
    logic [AE_W-1:0]  abs_ae;

    assign upper   = {s1_a[WIDTH-1], s1_a[WIDTH-1:SPLIT]} + {s1_b[WIDTH-1], s1_b[WIDTH-1:SPLIT]};
    assign appx_c  = {upper, lower};
    assign exact_c = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
    assign ae      = {exact_c[WIDTH], exact_c} - {appx_c[WIDTH], appx_c};
    assign abs_ae  = ae[AE_W-1] ? -ae : ae;

    // Saturating accumulation: any bit above ACC_W means the sum overflowed.
    logic [SQ_W-1:0]  sq;
    logic [EXT_W-1:0] ae_ext;
    logic [EXT_W-1:0] se_ext;
    logic [ACC_W-1:0] sum_ae_next;
    logic [ACC_W-1:0] sum_se_next;

    assign sq          = SQ_W'(s2_abs) * SQ_W'(s2_abs);
    assign ae_ext      = EXT_W'(sum_ae) + EXT_W'(s2_abs);
    assign se_ext      = EXT_W'(sum_se) + EXT_W'(sq);
    assign sum_ae_next = (|ae_ext[EXT_W-1:ACC_W]) ? '1 : ae_ext[ACC_W-1:0];
    assign sum_se_next = (|se_ext[EXT_W-1:ACC_W]) ? '1 : se_ext[ACC_W-1:0];

    // Three-stage pipeline; it never stalls, so valids just shift along.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid      <= 1'b0;
            s1_a          <= '0;
            s1_b          <= '0;
            s2_valid      <= 1'b0;
            s2_abs        <= '0;
            s3_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.appx_sum  <= '0;
            bus.exact_sum <= '0;
        end else begin
            s1_valid      <= transfer;
            if (transfer) begin
                s1_a <= bus.data_a;
                s1_b <= bus.data_b;
            end
            s2_valid      <= s1_valid;
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.appx_sum  <= appx_c;
                bus.exact_sum <= exact_c;
                s2_abs        <= abs_ae;
            end
            s3_valid      <= s2_valid;
        end
    end

    // Window control plus metric registers; metrics only move in RUN/DRAIN,
    // so the clear on an accepted start never collides with an update.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_cnt   <= '0;
            target       <= '0;
            sum_ae       <= '0;
            sum_se       <= '0;
            max_ae       <= '0;
            err_cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        target     <= num_samples;
                        sum_ae     <= '0;
                        sum_se     <= '0;
                        max_ae     <= '0;
                        err_cnt    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        if (num_samples == '0) begin
                            state        <= DRAIN;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state        <= RUN;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (transfer) begin
                        sample_cnt <= cnt_next;
                        if (cnt_next == target) begin
                            state        <= DRAIN;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid && !s3_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (metric_en) begin
                sum_ae <= sum_ae_next;
                sum_se <= sum_se_next;
                if (s2_abs > max_ae) begin
                    max_ae <= s2_abs;
                end
                if ((s2_abs != '0) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_etai_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_etai_err_monitor
// Directed bench for etai_err_monitor. Two instances share the stimulus: the
// default configuration and one with 8-bit accumulators for saturation.
// Per-sample results are predicted into a scoreboard queue when operands
// are accepted and popped when out_valid appears; window metrics come from
// a reference model of the ETAI adder kept alongside.
// ---------------------------------------------------------------------------
module tb_etai_err_monitor;
    localparam int WIDTH = 32;
    localparam int SPLIT = 16;
    localparam int CNT_W = 32;

    typedef struct {
        longint appx;
        longint exact;
        int     cyc;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             tb_start = 1'b0;
    logic [CNT_W-1:0] tb_num = '0;
    logic             tb_valid = 1'b0;
    logic [WIDTH-1:0] tb_a = '0;
    logic [WIDTH-1:0] tb_b = '0;

    logic [95:0]      sum_ae_m, sum_se_m;
    logic [WIDTH+1:0] max_ae_m, max_ae_s;
    logic [CNT_W-1:0] err_cnt_m, err_cnt_s;
    logic             busy_m, done_m, busy_s, done_s;
    logic [7:0]       sum_ae_s, sum_se_s;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;
    exp_t sb[$];

    longint model_sum_ae, model_sum_se, model_max, model_err;
    longint model_ae8, model_se8;

    etai_err_monitor_if #(.WIDTH(WIDTH)) bus_m ();
    etai_err_monitor_if #(.WIDTH(WIDTH)) bus_s ();

    assign bus_m.in_valid = tb_valid;
    assign bus_m.data_a   = tb_a;
    assign bus_m.data_b   = tb_b;
    assign bus_s.in_valid = tb_valid;
    assign bus_s.data_a   = tb_a;
    assign bus_s.data_b   = tb_b;

    etai_err_monitor #(.WIDTH(WIDTH), .SPLIT(SPLIT), .ACC_W(96), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(tb_start), .num_samples(tb_num), .bus(bus_m),
        .sum_ae(sum_ae_m), .sum_se(sum_se_m), .max_ae(max_ae_m), .err_cnt(err_cnt_m),
        .busy(busy_m), .done(done_m)
    );

    etai_err_monitor #(.WIDTH(WIDTH), .SPLIT(SPLIT), .ACC_W(8), .CNT_W(CNT_W)) dut_sat (
        .Clk(Clk), .Rst_n(Rst_n), .start(tb_start), .num_samples(tb_num), .bus(bus_s),
        .sum_ae(sum_ae_s), .sum_se(sum_se_s), .max_ae(max_ae_s), .err_cnt(err_cnt_s),
        .busy(busy_s), .done(done_s)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ETAI: locate the highest lower-part bit where both are 1 by an
    // upward scan, then OR a mask of ones from that bit down into a^b.
    function automatic longint etaiModel(input longint a, input longint b);
        logic [SPLIT-1:0] la, lb;
        int     k;
        longint lower, upper;
        la = a[SPLIT-1:0];
        lb = b[SPLIT-1:0];
        k  = -1;
        for (int i = 0; i < SPLIT; i++) if (la[i] && lb[i]) k = i;
        lower = longint'(la ^ lb);
        if (k >= 0) lower = lower | ((longint'(1) <<< (k + 1)) - 1);
        upper = (a >>> SPLIT) + (b >>> SPLIT);
        return upper * (longint'(1) <<< SPLIT) + lower;
    endfunction

    task automatic modelClear();
        model_sum_ae = 0; model_sum_se = 0; model_max = 0; model_err = 0;
        model_ae8 = 0; model_se8 = 0;
    endtask

    // Drive one operand pair; predict acceptance and, if accepted, the result.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic expect_accept);
        longint sa, sb_, ap, ex, ab;
        exp_t e;
        @(negedge Clk);
        tb_valid = 1'b1;
        tb_a = a;
        tb_b = b;
        checkOutput("in_ready", bus_m.in_ready, expect_accept);
        if (expect_accept) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            ap = etaiModel(sa, sb_);
            ex = sa + sb_;
            ab = (ex > ap) ? ex - ap : ap - ex;
            e.appx = ap; e.exact = ex; e.cyc = cyc;
            sb.push_back(e);
            model_sum_ae += ab;
            model_sum_se += ab * ab;
            if (ab > model_max) model_max = ab;
            if (ab != 0) model_err++;
            model_ae8 = (model_ae8 + ab > 255) ? 255 : model_ae8 + ab;
            model_se8 = (model_se8 + ab * ab > 255) ? 255 : model_se8 + ab * ab;
        end
    endtask

    task automatic idleInput();
        @(negedge Clk);
        tb_valid = 1'b0;
    endtask

    task automatic startWindow(input int n, input bit accepted);
        @(negedge Clk);
        tb_start = 1'b1;
        tb_num = CNT_W'(n);
        if (accepted) modelClear();
        @(negedge Clk);
        tb_start = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 60; i++) begin
            if (done_m) break;
            @(negedge Clk);
        end
        checkOutput("done_reached", done_m, 1'b1);
        checkOutput("busy_after", busy_m, 1'b0);
        checkOutput("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic checkMetrics(input string tag);
        checkOutput({tag, "_sum_ae"}, sum_ae_m, 128'(model_sum_ae));
        checkOutput({tag, "_sum_se"}, sum_se_m, 128'(model_sum_se));
        checkOutput({tag, "_max_ae"}, max_ae_m, 128'(model_max));
        checkOutput({tag, "_err_cnt"}, err_cnt_m, 128'(model_err));
    endtask

    // Scoreboard consumer: every out_valid must match the oldest prediction
    // and appear exactly two cycles after its transfer.
    always @(negedge Clk) begin
        exp_t e;
        if (Rst_n && bus_m.out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out_valid", bus_m.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                checkOutput("appx_sum", bus_m.appx_sum, 128'(e.appx));
                checkOutput("exact_sum", bus_m.exact_sum, 128'(e.exact));
                checkOutput("latency", 128'(cyc - e.cyc), 128'(2));
            end
        end
    end

    initial begin
        modelClear();
        // Reset state.
        #12;
        checkOutput("rst_in_ready", bus_m.in_ready, 1'b0);
        checkOutput("rst_out_valid", bus_m.out_valid, 1'b0);
        checkOutput("rst_busy", busy_m, 1'b0);
        checkOutput("rst_done", done_m, 1'b0);
        checkOutput("rst_sum_ae", sum_ae_m, 128'(0));
        checkOutput("rst_err_cnt", err_cnt_m, 128'(0));
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single sample (6,6): appx 7, exact 12, AE 5.
        $display("[TB] single sample");
        startWindow(1, 1'b1);
        checkOutput("run_busy", busy_m, 1'b1);
        applyStimulus(32'h6, 32'h6, 1'b1);
        idleInput();
        waitDone();
        checkMetrics("single");
        checkOutput("single_sum_se_const", sum_se_m, 128'(25));

        // in_valid held high in DONE: nothing accepted.
        applyStimulus(32'h7, 32'h9, 1'b0);
        applyStimulus(32'h7, 32'h9, 1'b0);

        // Window of 3 from DONE, with an ignored start in the middle.
        $display("[TB] window of three");
        idleInput();
        startWindow(3, 1'b1);
        checkOutput("restart_cleared", sum_ae_m, 128'(0));
        checkOutput("restart_done_low", done_m, 1'b0);
        applyStimulus(32'h3, 32'h1, 1'b1);
        idleInput();
        startWindow(1, 1'b0);
        checkOutput("start_in_run_ready", bus_m.in_ready, 1'b1);
        applyStimulus(32'h6, 32'h6, 1'b1);
        applyStimulus(32'h10000, 32'h20000, 1'b1);
        applyStimulus(32'h1234, 32'h1, 1'b0);
        idleInput();
        waitDone();
        checkMetrics("win3");
        checkOutput("win3_sum_ae_const", sum_ae_m, 128'(6));
        checkOutput("win3_sum_se_const", sum_se_m, 128'(26));

        // Sign handling.
        $display("[TB] sign handling");
        startWindow(2, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'h1, 1'b1);
        applyStimulus(32'h8000, 32'h8000, 1'b1);
        idleInput();
        waitDone();
        checkMetrics("sign");
        checkOutput("sign_max_const", max_ae_m, 128'(1));

        // Saturation on the 8-bit accumulator instance.
        $display("[TB] saturation");
        startWindow(11, 1'b1);
        for (int i = 0; i < 11; i++) applyStimulus(32'h6, 32'h6, 1'b1);
        idleInput();
        waitDone();
        checkMetrics("sat_main");
        checkOutput("sat_sum_se", sum_se_s, 128'(model_se8));
        checkOutput("sat_sum_se_const", sum_se_s, 128'(255));
        checkOutput("sat_sum_ae", sum_ae_s, 128'(model_ae8));
        checkOutput("sat_err_cnt", err_cnt_s, 128'(11));

        // Empty window: done two edges after start, metrics cleared.
        $display("[TB] empty window");
        startWindow(0, 1'b1);
        @(negedge Clk);
        checkOutput("empty_done", done_m, 1'b1);
        checkMetrics("empty");

        // Reset with two samples in flight.
        $display("[TB] reset mid-run");
        startWindow(5, 1'b1);
        applyStimulus(32'h1, 32'h2, 1'b1);
        applyStimulus(32'h3, 32'h4, 1'b1);
        @(posedge Clk);
        #1;
        tb_valid = 1'b0;
        Rst_n = 1'b0;
        sb.delete();
        modelClear();
        #1;
        checkOutput("midrst_out_valid", bus_m.out_valid, 1'b0);
        checkOutput("midrst_busy", busy_m, 1'b0);
        checkOutput("midrst_in_ready", bus_m.in_ready, 1'b0);
        checkMetrics("midrst");
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checkOutput("post_rst_out_valid", bus_m.out_valid, 1'b0);
        end
        checkOutput("post_rst_done", done_m, 1'b0);

        // Recovery window after reset.
        startWindow(1, 1'b1);
        applyStimulus(32'h5, 32'h5, 1'b1);
        idleInput();
        waitDone();
        checkMetrics("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
